// File: rtl/object_bound_monitor.sv
// +--------------------------------------------------------------------------+
// | object_bound_monitor                                                     |
// | Per-object window visibility tracking with sticky exit flags and an      |
// | optional saturating miss counter (enabled by macro OBB_MISS_COUNTER_EN). |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module object_bound_monitor #(
  parameter int N_OBJ = 4,
  parameter int WIN_W = 640,
  parameter int WIN_H = 480,
  parameter int NEG_X = 900,
  parameter int NEG_Y = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_OBJ-1:0]     obj_active,
  input  logic [10*N_OBJ-1:0]  posx_bus,
  input  logic [9*N_OBJ-1:0]   posy_bus,
  input  logic [10*N_OBJ-1:0]  width_bus,
  input  logic [9*N_OBJ-1:0]   height_bus,
  input  logic [N_OBJ-1:0]     ack,
  input  logic                 miss_clr,
  output logic [N_OBJ-1:0]     out_flag,
  output logic [N_OBJ-1:0]     exit_pulse,
  output logic [7:0]           miss_count
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_PENDING = 3'd1;
  localparam logic [2:0] c_ARMED   = 3'd2;
  localparam logic [2:0] c_EXITED  = 3'd3;
  localparam logic [2:0] c_RETIRED = 3'd4;

  localparam logic [10:0] c_WIN_W = 11'(WIN_W);
  localparam logic [10:0] c_WIN_H = 11'(WIN_H);
  localparam logic [10:0] c_NEG_X = 11'(NEG_X);
  localparam logic [10:0] c_NEG_Y = 11'(NEG_Y);

  logic [N_OBJ-1:0] w_exit;

  generate
    for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
      logic [10:0] w_px, w_wd, w_py, w_ht;
      logic        w_xout, w_yout, w_out;
      logic        act_q, on_q, out_q, pulse_q;
      logic [2:0]  state_q, state_d;
      logic        exit_d;

      // Coordinates at or above NEG_* wrap to negative values, so the right/bottom edge decides.
      assign w_px   = {1'b0, posx_bus[10*i +: 10]};
      assign w_wd   = {1'b0, width_bus[10*i +: 10]};
      assign w_py   = {2'b00, posy_bus[9*i +: 9]};
      assign w_ht   = {2'b00, height_bus[9*i +: 9]};
      assign w_xout = (w_px < c_NEG_X) ? (w_px >= c_WIN_W) : ((w_px + w_wd) <= 11'd1024);
      assign w_yout = (w_py < c_NEG_Y) ? (w_py >= c_WIN_H) : ((w_py + w_ht) <= 11'd512);
      assign w_out  = w_xout | w_yout;

      always_comb begin
        state_d = state_q;
        exit_d  = 1'b0;
        if (!act_q) begin
          state_d = c_IDLE;
        end else begin
          case (state_q)
            c_IDLE:    state_d = c_PENDING;
            c_PENDING: if (on_q) state_d = c_ARMED;
            c_ARMED:   if (out_q) begin
                         state_d = c_EXITED;
                         exit_d  = 1'b1;
                       end
            c_EXITED:  if (ack[i]) state_d = c_RETIRED;
            c_RETIRED: state_d = c_RETIRED;
            default:   state_d = c_IDLE;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          act_q   <= 1'b0;
          on_q    <= 1'b0;
          out_q   <= 1'b0;
          state_q <= c_IDLE;
          pulse_q <= 1'b0;
        end else begin
          act_q   <= obj_active[i];
          on_q    <= ~w_out;
          out_q   <= w_out;
          state_q <= state_d;
          pulse_q <= exit_d;
        end
      end

      assign out_flag[i]   = (state_q == c_EXITED);
      assign exit_pulse[i] = pulse_q;
      assign w_exit[i]     = exit_d;
    end
  endgenerate

`ifdef OBB_MISS_COUNTER_EN
  logic [7:0] miss_q, miss_d;
  logic [3:0] w_nexit;
  logic [8:0] w_sum;

  assign w_nexit = 4'($countones(w_exit));
  // A clear still counts exits landing on the same edge.
  assign w_sum   = miss_clr ? {5'd0, w_nexit} : ({1'b0, miss_q} + {5'd0, w_nexit});
  assign miss_d  = w_sum[8] ? 8'hFF : w_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miss_q <= 8'd0;
    else        miss_q <= miss_d;
  end

  assign miss_count = miss_q;
`else
  logic w_unused;
  assign w_unused   = ^{miss_clr, w_exit};
  assign miss_count = 8'd0;
`endif

endmodule

`default_nettype wire
